// File: rtl/div_sequencer_pkg.sv
// Shared sequencer definitions for the iterative Div/Mult units.
// State encoding, Moore output decode and HI/LO commit mapping.
package div_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } seq_state_t;

  localparam bit HILO_MIPS     = 1'b1;
  localparam bit HILO_STRAIGHT = 1'b0;

  typedef struct packed {
    logic busy;
    logic ctrl;
    logic rst;
    logic done;
  } seq_moore_t;

  function automatic seq_moore_t moore_out(input seq_state_t s);
    seq_moore_t o;
    o      = '0;
    o.busy = (s != S_IDLE);
    o.ctrl = (s == S_LOAD) || (s == S_RUN);
    o.rst  = (s == S_ERR);
    o.done = (s == S_DONE);
    return o;
  endfunction

  // Returns {hi, lo}; MIPS puts the remainder in HI.
  function automatic logic [63:0] hilo_map(
    input bit          swap,
    input logic [31:0] quo,
    input logic [31:0] rem
  );
    return swap ? {rem, quo} : {quo, rem};
  endfunction

endpackage

// File: rtl/div_sequencer.sv
// Drives the iterative Div unit for DIV instructions and commits
// its result into the architectural HI/LO registers.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter logic [31:0] TIMEOUT   = 32'd65536,
  parameter bit          HILO_SWAP = HILO_MIPS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic        div0_exc,
  output logic        ovr_exc,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_ctrl,
  output logic        div_rst,
  input  logic        div_done,
  input  logic        div_zero,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo
);

  seq_state_t  state;
  seq_state_t  nxt;
  seq_moore_t  mo;
  logic [31:0] cnt;
  logic        latch;
  logic        capture;
  logic        set_d0;
  logic        set_ov;
  logic        cnt_clr;
  logic        cnt_inc;
  logic [63:0] hilo;

  always_comb begin
    nxt     = state;
    latch   = 1'b0;
    capture = 1'b0;
    set_d0  = 1'b0;
    set_ov  = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start && !abort) begin
          latch = 1'b1;
          nxt   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          nxt = S_ERR;
        end else begin
          cnt_clr = 1'b1;
          nxt     = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          nxt = S_ERR;
        end else if (div_zero) begin
          set_d0 = 1'b1;
          nxt    = S_ERR;
        end else if (div_done) begin
          capture = 1'b1;
          nxt     = S_DONE;
        end else if (TIMEOUT != 32'd0 &&
                     cnt == TIMEOUT - 32'd1) begin
          set_ov = 1'b1;
          nxt    = S_ERR;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_DONE:  nxt = S_IDLE;
      S_ERR:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  assign mo   = moore_out(nxt);
  assign hilo = hilo_map(HILO_SWAP, div_hi, div_lo);

  // Outputs are registered from the next state, so they are pure
  // functions of the current state as seen outside.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      div0_exc <= 1'b0;
      ovr_exc  <= 1'b0;
      div_ctrl <= 1'b0;
      div_rst  <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
      div_a    <= '0;
      div_b    <= '0;
      cnt      <= '0;
    end else begin
      state    <= nxt;
      busy     <= mo.busy;
      done     <= mo.done;
      div_ctrl <= mo.ctrl;
      div_rst  <= mo.rst;
      div0_exc <= set_d0;
      ovr_exc  <= set_ov;
      if (latch) begin
        div_a <= op_a;
        div_b <= op_b;
      end
      if (capture) begin
        hi_out <= hilo[63:32];
        lo_out <= hilo[31:0];
      end
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer with a behavioural iterative Div unit.
// Expected HI/LO, event kind and due cycle go through a scoreboard.
module tb_div_sequencer;

  localparam logic [2:0] K_DONE = 3'b001;
  localparam logic [2:0] K_DIV0 = 3'b010;
  localparam logic [2:0] K_OVR  = 3'b100;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic        div0_exc;
  logic        ovr_exc;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_ctrl;
  logic        div_rst;
  logic        div_done;
  logic        div_zero;
  logic [31:0] div_hi;
  logic [31:0] div_lo;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [2:0]  kind;
    int          due;
    logic [31:0] hi;
    logic [31:0] lo;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  div_sequencer #(
    .TIMEOUT  (32'd8),
    .HILO_SWAP(1'b1)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .div0_exc(div0_exc),
    .ovr_exc (ovr_exc),
    .hi_out  (hi_out),
    .lo_out  (lo_out),
    .div_a   (div_a),
    .div_b   (div_b),
    .div_ctrl(div_ctrl),
    .div_rst (div_rst),
    .div_done(div_done),
    .div_zero(div_zero),
    .div_hi  (div_hi),
    .div_lo  (div_lo)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // Behavioural Div unit: inits on the first enabled edge, then takes
  // |quotient|+1 enabled edges before raising DivDone.
  logic        [31:0] ma, mb, m_hi, m_lo;
  logic signed [31:0] mq, mr;
  logic               m_init, m_dd, m_dz;
  int                 mc, mn;

  always_comb begin
    mq = '0;
    mr = '0;
    if (mb != 32'd0) begin
      mq = $signed(ma) / $signed(mb);
      mr = $signed(ma) % $signed(mb);
    end
    mn = (mq < 0) ? (-int'(mq) + 1) : (int'(mq) + 1);
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      ma <= '0; mb <= '0; m_hi <= '0; m_lo <= '0;
      m_init <= 1'b0; m_dd <= 1'b0; m_dz <= 1'b0; mc <= 0;
    end else if (div_rst) begin
      m_init <= 1'b0; m_dd <= 1'b0; m_dz <= 1'b0; mc <= 0;
    end else if (!div_ctrl) begin
      m_init <= 1'b0;
    end else if (!m_init || m_dd) begin
      m_init <= 1'b1; m_dd <= 1'b0; m_dz <= 1'b0; mc <= 0;
      ma <= div_a; mb <= div_b;
    end else if (mb == 32'd0) begin
      m_dz <= 1'b1;
    end else if (mc == mn - 1) begin
      m_dd <= 1'b1; m_hi <= mq; m_lo <= mr;
    end else begin
      mc <= mc + 1;
    end
  end

  assign div_done = m_dd;
  assign div_zero = m_dz;
  assign div_hi   = m_hi;
  assign div_lo   = m_lo;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && (done || div0_exc || ovr_exc)) begin
      if (sb.size() == 0) begin
        check("unexpected_event", {29'd0, ovr_exc, div0_exc, done}, 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_kind"}, {29'd0, ovr_exc, div0_exc, done},
              {29'd0, e.kind});
        check({e.tag, "_cycle"}, 32'(cyc), 32'(e.due));
        check({e.tag, "_hi"}, hi_out, e.hi);
        check({e.tag, "_lo"}, lo_out, e.lo);
        check({e.tag, "_divrst"}, {31'd0, div_rst},
              {31'd0, e.kind != K_DONE});
      end
    end
  end

  // Called at a negedge; the following posedge is the start edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] kind, input int lat,
                       input logic [31:0] ehi, input logic [31:0] elo,
                       input string tag);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    sb.push_back('{kind, cyc + 1 + lat, ehi, elo, tag});
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (n < 300) begin
      @(negedge clock);
      #1;
      if (sb.size() == 0 && !busy) break;
      n++;
    end
    check({tag, "_drain"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (2) @(negedge clock);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi_out, 32'd0);
    check("rst_lo", lo_out, 32'd0);
    check("rst_diva", div_a, 32'd0);
    check("rst_ctrl", {31'd0, div_ctrl}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    issue(-32'sd7, 32'sd3, K_DONE, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "neg_pos");
    wait_idle("neg_pos");
    issue(-32'sd7, -32'sd3, K_DONE, 5, 32'hFFFF_FFFF, 32'd2, "neg_neg");
    wait_idle("neg_neg");

    issue(32'd7, 32'd3, K_DONE, 5, 32'd1, 32'd2, "d7_3");
    while (sb.size() != 0 && cyc < 1000) @(negedge clock);
    @(negedge clock);
    check("idle_after_done", {31'd0, busy}, 32'd0);

    issue(32'd5, 32'd0, K_DIV0, 3, 32'd1, 32'd2, "div0");
    wait_idle("div0");
    issue(32'd9, 32'd4, K_DONE, 5, 32'd1, 32'd2, "d9_4");
    wait_idle("d9_4");

    issue(32'd100, 32'd1, K_OVR, 9, 32'd1, 32'd2, "ovr");
    wait_idle("ovr");
    check("rearm", {29'd0, m_init, m_dd, m_dz}, 32'd0);
    issue(-32'sd9, 32'sd2, K_DONE, 7, 32'hFFFF_FFFF, 32'hFFFF_FFFC, "after_ovr");
    wait_idle("after_ovr");

    // Abort two cycles into RUN.
    @(negedge clock);
    issue(32'd100, 32'd1, K_DONE, 0, 32'd0, 32'd0, "abort");
    void'(sb.pop_back());
    repeat (2) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd1);
    check("abort_divrst", {31'd0, div_rst}, 32'd1);
    check("abort_flags", {30'd0, ovr_exc, div0_exc}, 32'd0);
    check("abort_hi", hi_out, 32'hFFFF_FFFF);
    check("abort_lo", lo_out, 32'hFFFF_FFFC);
    @(negedge clock);
    check("abort_idle", {31'd0, busy}, 32'd0);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clock);
    check("start_abort_ignored", {31'd0, busy}, 32'd0);
    start = 1'b0;
    abort = 1'b0;

    // Async reset between edges during RUN.
    issue(32'd7, 32'd3, K_DONE, 0, 32'd0, 32'd0, "mid_rst");
    void'(sb.pop_back());
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_ctrl", {31'd0, div_ctrl}, 32'd0);
    check("arst_hi", hi_out, 32'd0);
    check("arst_lo", lo_out, 32'd0);
    check("arst_diva", div_a, 32'd0);
    check("arst_divb", div_b, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Start held: ignored in DONE, accepted in the next IDLE.
    op_a  = 32'd9;
    op_b  = 32'd4;
    start = 1'b1;
    sb.push_back('{K_DONE, cyc + 1 + 5, 32'd1, 32'd2, "held1"});
    sb.push_back('{K_DONE, cyc + 1 + 7 + 5, 32'd1, 32'd2, "held2"});
    repeat (7) @(negedge clock);
    check("held_idle", {31'd0, busy}, 32'd0);
    @(negedge clock);
    check("held_load", {31'd0, busy}, 32'd1);
    start = 1'b0;
    wait_idle("held");

    repeat (3) @(negedge clock);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
